// File: rtl/note_tone_gen.sv
// note_tone_gen: turns the 4-bit note code into a square-wave tone.
// A code must hold steady for SETTLE_CYCLES samples before it is accepted.
// The accepted code then selects a half-period count, and a free-running
// divider toggles the tone output at that rate.
`timescale 1ns/1ps

module note_tone_gen #(
    parameter int SETTLE_CYCLES = 4,
    parameter int DIV_SHIFT     = 0
) (
    input  logic       CLK,
    input  logic       RESET_N,
    input  logic [3:0] note_in,
    output logic       tone,
    output logic       playing,
    output logic [3:0] cur_note,
    output logic       note_chg
);

    localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CW-1:0] SETTLE_MAX = CW'(SETTLE_CYCLES - 1);

    typedef enum logic {
        IDLE,
        PLAY
    } state_t;

    // Half-period in clock cycles for each note, scaled down by DIV_SHIFT.
    // The result never drops below one cycle.
    function automatic logic [17:0] halfOf(input logic [3:0] code);
        logic [17:0] base;
        logic [17:0] shifted;
        case (code)
            4'd1:    base = 18'd191110;
            4'd2:    base = 18'd170265;
            4'd3:    base = 18'd151685;
            4'd4:    base = 18'd143172;
            4'd5:    base = 18'd127551;
            4'd6:    base = 18'd113636;
            4'd7:    base = 18'd101239;
            4'd8:    base = 18'd95557;
            default: base = 18'd1;
        endcase
        shifted = base >> DIV_SHIFT;
        return (shifted == 18'd0) ? 18'd1 : shifted;
    endfunction

    logic [3:0]    w_noteNorm;
    logic          w_accept;
    logic [17:0]   w_halfM1;
    logic [3:0]    r_cand;
    logic [CW-1:0] r_settleCnt;
    logic [3:0]    r_cur;
    logic          r_noteChg;
    logic          r_tone;
    logic [17:0]   r_div;
    state_t        r_state;
    state_t        w_nextState;

    // Codes 9-15 mean "no note", so fold them to 0 before anything looks at them.
    always_comb begin
        w_noteNorm = note_in;
        if (note_in > 4'd8) begin
            w_noteNorm = 4'd0;
        end
    end

    // Accept once the candidate has been stable long enough and differs from the current note.
    always_comb begin
        w_accept = (r_settleCnt == SETTLE_MAX) && (r_cand == w_noteNorm) && (r_cand != r_cur);
        w_halfM1 = halfOf(r_cur) - 18'd1;
    end

    // Track the most recent code and how long it has stayed unchanged, saturating at the limit.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_cand      <= 4'd0;
            r_settleCnt <= '0;
        end else if (w_noteNorm != r_cand) begin
            r_cand      <= w_noteNorm;
            r_settleCnt <= '0;
        end else if (r_settleCnt != SETTLE_MAX) begin
            r_settleCnt <= r_settleCnt + CW'(1);
        end
    end

    // Latch the accepted code and pulse the change flag for exactly that cycle.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_cur     <= 4'd0;
            r_noteChg <= 1'b0;
        end else begin
            r_noteChg <= w_accept;
            if (w_accept) begin
                r_cur <= r_cand;
            end
        end
    end

    // State register.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic: a non-zero acceptance starts playback, accepting "none" stops it.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE: if (w_accept && (r_cand != 4'd0)) w_nextState = PLAY;
            PLAY: if (w_accept && (r_cand == 4'd0)) w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    // Output logic for the state machine.
    always_comb begin
        playing = 1'b0;
        if (r_state == PLAY) begin
            playing = 1'b1;
        end
    end

    // Tone divider. An acceptance wins over a terminal count, so every new note starts low from phase zero.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_div  <= 18'd0;
            r_tone <= 1'b0;
        end else if (w_accept) begin
            r_div  <= 18'd0;
            r_tone <= 1'b0;
        end else if (r_state == PLAY) begin
            if (r_div == w_halfM1) begin
                r_div  <= 18'd0;
                r_tone <= ~r_tone;
            end else begin
                r_div <= r_div + 18'd1;
            end
        end else begin
            r_div  <= 18'd0;
            r_tone <= 1'b0;
        end
    end

    assign tone     = r_tone;
    assign cur_note = r_cur;
    assign note_chg = r_noteChg;

endmodule
